// File: rtl/serial_word_shifter.sv
// serial_word_shifter
//   Parallel-to-serial front end for the bit-serial sequence detectors.
//   Words arrive over a valid/ready handshake. Each word is shifted out MSB
//   first, one bit per cycle with en high, on sout qualified by sout_valid.
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
//   din_ready depends only on registered state, never on din_valid or en.
//   Downstream consumes a bit in every cycle where sout_valid && en.
//
// Optional feature: define SERIAL_WORD_SHIFTER_DBUF_EN to add a one-word
//   holding register. This allows zero-bubble word-to-word streaming. Without
//   it, consecutive words are separated by one idle cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   din          parallel word to serialize
//   din_valid    din holds a word
//   din_ready    block can accept a word this cycle
//   en           shift enable; low holds the current bit
//   sout         serial bit, MSB first, 0 when sout_valid is 0
//   sout_valid   sout carries a word bit
//   word_done    the last bit of a word is being consumed (combinational)
//   busy         a word is shifting or buffered
//   dbg_state_o  current FSM state (0 = IDLE, 1 = SHIFT)
module serial_word_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              last_bit;
  logic              hold_full;

`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  assign hold_full = hold_full_q;
  assign din_ready = !hold_full_q;
`else
  assign hold_full = 1'b0;
  assign din_ready = (state_q == IDLE);
`endif

  assign accept      = din_valid && din_ready;
  assign last_bit    = (state_q == SHIFT) && en && (cnt_q == '0);
  assign word_done   = last_bit;
  assign sout_valid  = (state_q == SHIFT);
  assign sout        = (state_q == SHIFT) ? sreg_q[WIDTH-1] : 1'b0;
  assign busy        = (state_q == SHIFT) || hold_full;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q != '0) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - 1'b1;
          end else begin
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
            // A buffered word has priority. din_ready is low whenever hold is
            // full, so an accept here can only occur with hold empty.
            if (hold_full_q) begin
              sreg_d      = hold_q;
              hold_full_d = 1'b0;
              cnt_d       = CNT_LAST;
            end else if (accept) begin
              sreg_d = din;
              cnt_d  = CNT_LAST;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
    // An accept mid-word parks the word in hold. On the last-bit cycle the
    // word goes straight into sreg, as handled above.
    if ((state_q == SHIFT) && accept && !last_bit) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_shifter.sv
module tb_serial_word_shifter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         en;
  logic         sout;
  logic         sout_valid;
  logic         word_done;
  logic         busy;
  logic         dbg_state_o;

  int checks;
  int errors;
  bit en_rand;

  // Each entry is {last_bit_of_word, bit_value}, in line order.
  logic [1:0] exp_q[$];

  serial_word_shifter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .en         (en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .word_done  (word_done),
    .busy       (busy),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: every accepted word becomes W queue entries, MSB first.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back({(i == 0), w[i]});
    end
  endtask

  // Number of accepted words not yet fully consumed.
  function automatic int words_in_q();
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i][1]) n++;
    return n;
  endfunction

  // Driver: called at posedge+#1. Returns at posedge+#1 just after the accept edge.
  task automatic send_word(input logic [W-1:0] w);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    din = w;
    din_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (got) push_word(w);
    else begin
      checks++;
      errors++;
      $display("FAIL send_word timeout actual=no_accept required=accept");
    end
  endtask

  task automatic idle_cycles(input int n);
    din_valid = 1'b0;
    din = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random enable source
  always @(posedge clk) begin
    #1;
    if (en_rand) en = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] f;
      int nw;
      nw = words_in_q();
      check("sout_valid", sout_valid, (exp_q.size() != 0));
      check("busy", busy, (nw != 0));
      check("dbg_state", dbg_state_o, (exp_q.size() != 0));
`ifdef SERIAL_WORD_SHIFTER_DBUF_EN
      check("din_ready", din_ready, (nw < 2));
`else
      check("din_ready", din_ready, (nw == 0));
`endif
      if (sout_valid && exp_q.size() != 0) begin
        f = exp_q[0];
        check("sout_bit", sout, f[0]);
        check("word_done", word_done, (en && f[1]));
        if (en) void'(exp_q.pop_front());
      end else begin
        check("sout_idle", sout, 1'b0);
        check("word_done_idle", word_done, 1'b0);
      end
    end
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    en_rand   = 1'b0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    en        = 1'b0;
    #1;
    check("rst_sout", sout, 1'b0);
    check("rst_sout_valid", sout_valid, 1'b0);
    check("rst_word_done", word_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_din_ready", din_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single word, en high
    en = 1'b1;
    send_word(8'hB0);
    idle_cycles(10);

    // Stall on the third bit for three cycles
    send_word(8'hA5);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    idle_cycles(12);

    // Back-to-back with din_valid held
    send_word(8'hFF);
    send_word(8'h0F);
    idle_cycles(20);

    // Reset during the fourth bit
    send_word(8'hFF);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_sout", sout, 1'b0);
    check("midrst_sout_valid", sout_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_din_ready", din_ready, 1'b1);
    @(posedge clk);
    #1;

    // Idle line
    idle_cycles(20);

    // Randomized traffic with random enable
    en_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_word(W'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    din_valid = 1'b0;
    en_rand = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle_cycles(3);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
